// File: rtl/filt_pkg.sv
// Shared definitions for the decimating filter-to-UART bridge: default
// parameters, transmit FSM encoding and a counter-width helper.
package filt_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DECIM_DEF        = 4;
    localparam int FIFO_DEPTH_DEF   = 4;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A modulo-n counter needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/filt_fifo.sv
// Small synchronous FIFO holding captured filter samples until the UART
// transmitter is free. A push on a full FIFO is accepted only alongside a pop.
module filt_fifo
    import filt_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/filt_uart_tx.sv
// Decimates the upstream FIR output, buffers the captured samples and sends
// each one as an 8N1 UART frame. rst_n is active high despite its name.
module filt_uart_tx
    import filt_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DECIM        = DECIM_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    y_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [1:0]                    state
);

    localparam int DW = cnt_width(DECIM);
    localparam int BW = cnt_width(CLKS_PER_BIT);
    localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    logic [DW-1:0] dec_cnt;
    logic          cap_valid;
    logic [7:0]    cap_data;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;

    // The captured sample becomes a push request on the following edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dec_cnt   <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= (dec_cnt == DECIM_LAST);
            if (dec_cnt == DECIM_LAST) begin
                dec_cnt  <= '0;
                cap_data <= y_in;
            end else begin
                dec_cnt <= dec_cnt + DW'(1);
            end
        end
    end

    assign pop = (state == ST_IDLE) && !fifo_empty;

    filt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (cap_valid),
        .pop   (pop),
        .din   (cap_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow <= 1'b0;
        end else if (cap_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!fifo_empty) begin
                        shreg <= fifo_dout;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg[0];
            default:  tx = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_filt_uart_tx.sv
// Self-checking bench for filt_uart_tx: a frame-level reference model compared
// every cycle, a UART receiver collecting bytes, and literal timing checks.
module tb_filt_uart_tx;
    import filt_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] y_in = 8'h00;

    logic tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b, tx_c, busy_c, ovf_c;
    logic [LW-1:0] lvl_a, lvl_b, lvl_c;
    logic [1:0] st_a, st_b, st_c;

    filt_uart_tx #(.CLKS_PER_BIT(CPB), .DECIM(200), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst_n(rst), .y_in(y_in), .tx(tx_a), .busy(busy_a),
        .overflow(ovf_a), .level(lvl_a), .state(st_a));
    filt_uart_tx #(.CLKS_PER_BIT(CPB), .DECIM(4), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst_n(rst), .y_in(y_in), .tx(tx_b), .busy(busy_b),
        .overflow(ovf_b), .level(lvl_b), .state(st_b));
    filt_uart_tx #(.CLKS_PER_BIT(CPB), .DECIM(170), .FIFO_DEPTH(DEPTH)) u_c (
        .clk(clk), .rst_n(rst), .y_in(y_in), .tx(tx_c), .busy(busy_c),
        .overflow(ovf_c), .level(lvl_c), .state(st_c));

    always #5 clk = ~clk;

    int sel = 0;
    int m_decim = 200;
    logic tx_s, busy_s, ovf_s;
    logic [LW-1:0] lvl_s;
    logic [1:0] st_s;

    always_comb begin
        tx_s = tx_a; busy_s = busy_a; ovf_s = ovf_a; lvl_s = lvl_a; st_s = st_a;
        case (sel)
            1: begin tx_s = tx_b; busy_s = busy_b; ovf_s = ovf_b; lvl_s = lvl_b; st_s = st_b; end
            2: begin tx_s = tx_c; busy_s = busy_c; ovf_s = ovf_c; lvl_s = lvl_c; st_s = st_c; end
            default: ;
        endcase
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of samples plus the start edge of the frame on the line.
    logic [7:0] m_q[$];
    int         m_edge  = 0;
    bit         m_pend  = 0;
    logic [7:0] m_pend_b = 8'h00;
    bit         m_act   = 0;
    int         m_start = 0;
    logic [7:0] m_cur   = 8'h00;
    bit         m_ovf   = 0;
    bit         m_pop   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_edge = 0;
            m_pend = 0;
            m_act  = 0;
            m_ovf  = 0;
        end else begin
            m_edge++;
            m_pop = !m_act && (m_q.size() > 0);
            if (m_act && (m_edge - m_start) == 10 * CPB) m_act = 0;
            if (m_pop) begin
                m_cur   = m_q.pop_front();
                m_act   = 1;
                m_start = m_edge;
            end
            if (m_pend) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend_b);
                else m_ovf = 1;
            end
            m_pend   = (m_edge % m_decim) == 0;
            m_pend_b = y_in;
        end
    end

    function automatic logic exp_tx();
        int off;
        if (!m_act) return 1'b1;
        off = m_edge - m_start;
        if (off < CPB) return 1'b0;
        if (off < 9 * CPB) return m_cur[off / CPB - 1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("cyc_tx", {31'd0, tx_s}, {31'd0, exp_tx()});
        check("cyc_busy", {31'd0, busy_s}, {31'd0, m_act});
        check("cyc_overflow", {31'd0, ovf_s}, {31'd0, m_ovf});
        check("cyc_level", 32'(lvl_s), 32'(m_q.size()));
    end

    // UART receiver: centre-samples each bit of a frame seen on tx.
    int rx_cnt = -1;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (tx_s == 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(rx_sh);
                rx_cnt = -1;
            end else if (rx_cnt >= CPB + CPB / 2 && (rx_cnt % CPB) == CPB / 2) begin
                rx_sh = {tx_s, rx_sh[7:1]};
            end
        end
    end

    int lvl_max = 0;
    always @(negedge clk) if (!rst && sel == 2 && int'(lvl_s) > lvl_max) lvl_max = int'(lvl_s);

    task automatic run_to(input int n);
        int guard = 0;
        while (m_edge < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (m_edge < n) check("run_to_timeout", 32'(m_edge), 32'(n));
    endtask

    task automatic compare_rx(input string name);
        check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({name, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset(input int s, input int d);
        @(negedge clk);
        #2 rst = 1'b1;
        sel = s;
        m_decim = d;
        rx_q.delete();
        exp_q.delete();
        lvl_max = 0;
        repeat (2) @(negedge clk);
        check("rst_tx", {31'd0, tx_s}, 32'd1);
        check("rst_busy", {31'd0, busy_s}, 32'd0);
        check("rst_overflow", {31'd0, ovf_s}, 32'd0);
        check("rst_level", 32'(lvl_s), 32'd0);
        check("rst_state", 32'(st_s), 32'(ST_IDLE));
        #2 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single frame, DECIM=200, 0xA5; y_in changes away from the capture edge.
        y_in = 8'h00;
        do_reset(0, 200);
        run_to(150); y_in = 8'hA5;
        run_to(200); check("a_lvl_200", 32'(lvl_s), 32'd0);
        y_in = 8'hFF;
        run_to(201); check("a_lvl_201", 32'(lvl_s), 32'd1);
        check("a_busy_201", {31'd0, busy_s}, 32'd0);
        run_to(202); check("a_tx_202", {31'd0, tx_s}, 32'd0);
        check("a_busy_202", {31'd0, busy_s}, 32'd1);
        check("a_lvl_202", 32'(lvl_s), 32'd0);
        run_to(217); check("a_tx_217", {31'd0, tx_s}, 32'd0);
        run_to(218); check("a_tx_218", {31'd0, tx_s}, 32'd1);
        run_to(234); check("a_tx_234", {31'd0, tx_s}, 32'd0);
        run_to(361); check("a_busy_361", {31'd0, busy_s}, 32'd1);
        check("a_tx_361", {31'd0, tx_s}, 32'd1);
        run_to(362); check("a_busy_362", {31'd0, busy_s}, 32'd0);
        exp_q.push_back(8'hA5);
        compare_rx("a_rx");

        // Defaults with constant 0x3C: FIFO fills and a capture is dropped.
        y_in = 8'h3C;
        do_reset(1, 4);
        run_to(21); check("b_lvl_21", 32'(lvl_s), 32'd4);
        check("b_ovf_21", {31'd0, ovf_s}, 32'd0);
        run_to(24); check("b_ovf_24", {31'd0, ovf_s}, 32'd0);
        run_to(25); check("b_ovf_25", {31'd0, ovf_s}, 32'd1);
        check("b_lvl_25", 32'(lvl_s), 32'd4);
        run_to(600); check("b_ovf_600", {31'd0, ovf_s}, 32'd1);
        repeat (3) exp_q.push_back(8'h3C);
        compare_rx("b_rx");

        // Reset during DATA bit 3 of a 0x35 frame, then a fresh 0x5C frame.
        y_in = 8'h35;
        do_reset(1, 4);
        run_to(75); check("d_tx_pre", {31'd0, tx_s}, 32'd0);
        check("d_lvl_pre", 32'(lvl_s), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("d_tx_async", {31'd0, tx_s}, 32'd1);
        check("d_lvl_async", 32'(lvl_s), 32'd0);
        check("d_busy_async", {31'd0, busy_s}, 32'd0);
        check("d_ovf_async", {31'd0, ovf_s}, 32'd0);
        repeat (2) @(negedge clk);
        rx_q.delete();
        y_in = 8'h5C;
        #2 rst = 1'b0;
        run_to(4); check("d_lvl_4", 32'(lvl_s), 32'd0);
        run_to(5); check("d_lvl_5", 32'(lvl_s), 32'd1);
        run_to(6); check("d_tx_6", {31'd0, tx_s}, 32'd0);
        check("d_busy_6", {31'd0, busy_s}, 32'd1);
        run_to(170);
        exp_q.push_back(8'h5C);
        compare_rx("d_rx");

        // Ordering, DECIM=170: incrementing samples with junk between captures.
        do_reset(2, 170);
        for (int k = 0; k < 6; k++) begin
            for (int c = 1; c <= 170; c++) begin
                y_in = (c == 170) ? 8'(k) : 8'($urandom_range(0, 255));
                @(negedge clk);
            end
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(k));
        compare_rx("c_rx");
        check("c_ovf", {31'd0, ovf_s}, 32'd0);
        check("c_lvl_max_le1", {31'd0, lvl_max <= 1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
